mux_scan: RTL and testbench
===========================

# mux_scan

Parametrised, registered N-channel, W-bit selector: the clocked successor of the team's combinational 4:1 reset mux. It offers a manual mode, where the channel is chosen by `i_con`, and an auto-scan mode, where a round-robin sequencer steps through all channels with a programmable dwell time. It sits between the channel inputs and any downstream sampling logic and flags each new sample with a one-cycle strobe.

## Interface

**Parameters**
- `W`, default 1: data width per channel (≥1).
- `N`, default 4: channel count (≥2; need not be a power of 2).
- `SW`, default `$clog2(N)`: select width. Derived; do not override.
- `DWELL`, default 8: cycles per channel in scan mode (≥1).

**Ports**
- `clk`, in, 1: single clock, rising edge.
- `rs_n`, in, 1: reset, asynchronous, active-low.
- `i_data`, in, N*W: flat channel bus; channel k occupies bits [k*W +: W].
- `i_con`, in, SW: manual channel select.
- `i_mode`, in, 1: 0 = manual, 1 = scan.
- `i_en`, in, 1: advance/sample enable.
- `i_clr`, in, 1: synchronous clear.
- `o_data`, out, W: registered selected data.
- `o_sel`, out, SW: channel index that produced `o_data`.
- `o_valid`, out, 1: one-cycle strobe, new sample on `o_data`.
- `o_wrap`, out, 1: one-cycle strobe, last channel of a scan pass sampled.

## Operation

- **Reset.** `rs_n` low: `o_data`=0, `o_sel`=0, `o_valid`=0, `o_wrap`=0, channel pointer `ch`=0, dwell counter `cnt`=0, and the stored-mode register=0. Reset takes effect immediately, without waiting for a clock edge.
- **Priority per edge:** `i_clr` > mode change > `i_en` low > normal operation.
- **`i_clr`=1:** all state and outputs take their reset values on that edge.
- **Mode change.** When `i_mode` differs from the stored mode:
  - Store the new mode.
  - Set `ch`=0 and `cnt`=0.
  - Drive `o_valid`=0 and `o_wrap`=0.
  - Hold `o_data` and `o_sel`.
  - No sample is taken on that edge.
- **`i_en`=0:**
  - `ch`, `cnt`, `o_data` and `o_sel` hold.
  - `o_valid`=0 and `o_wrap`=0.
- **Manual (`i_en`=1):**
  - Every edge: `o_data` ← channel `i_con`, `o_sel` ← `i_con`, `o_valid`=1, `o_wrap`=0.
  - If `i_con` ≥ N: `o_data` ← 0, `o_sel` ← `i_con`, `o_valid`=1.
- **Scan (`i_en`=1):**
  - If `cnt` < DWELL-1: `cnt` increments and `o_valid`=0.
  - If `cnt` = DWELL-1:
    - `o_data` ← channel `ch`, `o_sel` ← `ch`, `o_valid`=1, `cnt` ← 0.
    - If `ch` = N-1: `ch` ← 0 and `o_wrap`=1. Otherwise `ch` ← `ch`+1.
  - `i_con` is ignored in scan mode.
- **DWELL=1:** one sample per enabled cycle, with channels in order 0,1,…,N-1,0,….
- **Counter width:** `cnt` is sized `$clog2(DWELL)`, with a minimum of 1 bit. `ch` is SW bits and never exceeds N-1.

## Timing

- **Manual latency:** 1 cycle. Data and select present before edge k appear on `o_data`/`o_sel` after edge k, with `o_valid` high for that cycle.
- **Scan latency:** the first sample follows the DWELL-th enabled edge after the mode-change edge. Consecutive samples are DWELL enabled cycles apart.
- **Full scan pass:** N*DWELL enabled cycles. `o_wrap` coincides with the `o_valid` of channel N-1.
- **`i_en` gaps:** stretch timing without losing position. The sample occurs on the DWELL-th *enabled* cycle.
- **Strobes:** `o_valid` and `o_wrap` are never high for two consecutive cycles unless DWELL=1 (and, in manual mode, whenever `i_en` is held high).
- **Reset release:** in-flight scan progress is lost. With `i_mode`=1 held through reset, the first edge after release is a mode-change edge and takes no sample.

## Test plan

1. **Reset.** Hold `rs_n`=0 mid-scan with N=4, W=8 → all outputs are 0 asynchronously. After release with `i_mode`=0, `i_con`=2, `i_data`=0x44_33_22_11 → after one edge `o_data`=0x33, `o_sel`=2, `o_valid`=1.
2. **Manual sweep.** `i_con` = 0,1,2,3 on successive cycles → `o_data` = 0x11, 0x22, 0x33, 0x44, each one cycle later, with `o_valid` high every cycle.
3. **Scan.** DWELL=3, switch to `i_mode`=1 → `o_valid` pulses every 3rd edge with `o_sel` = 0,1,2,3,0. `o_wrap` pulses only alongside `o_sel`=3. The full pass takes 12 cycles.
4. **Enable gaps.** Scan with `i_en` dropped for 5 cycles mid-dwell → the next sample is delayed exactly 5 cycles and the channel order is preserved.
5. **Non-power-of-2 channel count.** N=3, manual `i_con`=3 → `o_data`=0, `o_sel`=3, `o_valid`=1. In scan mode the order is 0,1,2,0 with `o_wrap` at 2.
6. **Simultaneous events.**
   - `i_clr` and a mode change on the same edge → outputs are cleared.
   - A mode change to manual at `cnt`=DWELL-1 → no sample on that edge; the manual sample appears on the next edge.
   - DWELL=1 → `o_valid` is continuously high.

Source files
------------

// File: rtl/mux_scan.sv
// mux_scan: registered N-channel, W-bit selector with manual and auto-scan modes.
//
// In manual mode the channel is picked by i_con on every enabled edge. In scan
// mode a round-robin sequencer visits channels 0..N-1, taking one sample every
// DWELL enabled cycles. Each new sample is flagged on o_valid for one cycle;
// o_wrap marks the sample of the last channel of a scan pass.
//
// Handshake: there is no backpressure. o_valid is a pure one-cycle strobe that
// qualifies o_data/o_sel; a consumer that is not ready simply misses it.
//
// Ports
//   clk      : clock, rising edge
//   rs_n     : asynchronous active-low reset
//   i_data   : flat channel bus, channel k at bits [k*W +: W]
//   i_con    : manual channel select
//   i_mode   : 0 = manual, 1 = scan
//   i_en     : advance/sample enable
//   i_clr    : synchronous clear (highest priority)
//   o_data   : registered selected data
//   o_sel    : channel index that produced o_data
//   o_valid  : one-cycle strobe, new sample on o_data
//   o_wrap   : one-cycle strobe, last channel of a scan pass sampled
module mux_scan #(
    parameter int W     = 1,
    parameter int N     = 4,
    parameter int SW    = $clog2(N),
    parameter int DWELL = 8
) (
    input  logic           clk,
    input  logic           rs_n,
    input  logic [N*W-1:0] i_data,
    input  logic [SW-1:0]  i_con,
    input  logic           i_mode,
    input  logic           i_en,
    input  logic           i_clr,
    output logic [W-1:0]   o_data,
    output logic [SW-1:0]  o_sel,
    output logic           o_valid,
    output logic           o_wrap
);

    // Dwell counter needs at least one bit even when DWELL=1.
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [SW-1:0] CH_LAST  = SW'(N - 1);

    logic           mode_q,  mode_d;
    logic [SW-1:0]  ch_q,    ch_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [W-1:0]   data_q,  data_d;
    logic [SW-1:0]  sel_q,   sel_d;
    logic           valid_q, valid_d;
    logic           wrap_q,  wrap_d;

    // Unpack the flat bus so channels can be indexed directly.
    logic [W-1:0] chan [N];
    for (genvar k = 0; k < N; k++) begin : g_chan
        assign chan[k] = i_data[k*W +: W];
    end

    // Manual selects beyond the last channel read as zero (N need not be 2^SW).
    logic         con_in_range;
    logic [W-1:0] con_data;
    always_comb begin
        con_in_range = (32'(i_con) < N);
        con_data     = '0;
        if (con_in_range) begin
            con_data = chan[i_con];
        end
    end

    always_comb begin
        mode_d  = mode_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sel_d   = sel_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;

        if (i_clr) begin
            mode_d = 1'b0;
            ch_d   = '0;
            cnt_d  = '0;
            data_d = '0;
            sel_d  = '0;
        end else if (i_mode != mode_q) begin
            // Mode switch restarts the sequencer; outputs hold, no sample.
            mode_d = i_mode;
            ch_d   = '0;
            cnt_d  = '0;
        end else if (!i_en) begin
            // Hold position; strobes already default low.
        end else if (!mode_q) begin
            data_d  = con_data;
            sel_d   = i_con;
            valid_d = 1'b1;
        end else begin
            if (cnt_q == CNT_LAST) begin
                data_d  = chan[ch_q];
                sel_d   = ch_q;
                valid_d = 1'b1;
                cnt_d   = '0;
                if (ch_q == CH_LAST) begin
                    ch_d   = '0;
                    wrap_d = 1'b1;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            mode_q  <= 1'b0;
            ch_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_data  = data_q;
    assign o_sel   = sel_q;
    assign o_valid = valid_q;
    assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan.sv
// Bench for mux_scan: two instances share one control stream.
//   A: N=4, W=8, DWELL=3
//   B: N=3, W=8, DWELL=1 (non-power-of-2 channel count, continuous sampling)
// Expected outputs come from a model that counts enabled scan edges since the
// last mode entry and derives sample points and channel numbers arithmetically.
module tb_mux_scan;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rs_n;
    logic [31:0] data_a;
    logic [23:0] data_b;
    logic [1:0]  con;
    logic        mode, en, clr;

    assign data_b = data_a[23:0];

    logic [7:0] a_data, b_data;
    logic [1:0] a_sel, b_sel;
    logic       a_valid, b_valid, a_wrap, b_wrap;

    mux_scan #(.W(8), .N(4), .DWELL(3)) u_a (
        .clk(clk), .rs_n(rs_n), .i_data(data_a), .i_con(con), .i_mode(mode),
        .i_en(en), .i_clr(clr), .o_data(a_data), .o_sel(a_sel),
        .o_valid(a_valid), .o_wrap(a_wrap)
    );

    mux_scan #(.W(8), .N(3), .DWELL(1)) u_b (
        .clk(clk), .rs_n(rs_n), .i_data(data_b), .i_con(con), .i_mode(mode),
        .i_en(en), .i_clr(clr), .o_data(b_data), .o_sel(b_sel),
        .o_valid(b_valid), .o_wrap(b_wrap)
    );

    // ---------------- reference model ----------------
    int  m_n     [2] = '{4, 3};
    int  m_dwell [2] = '{3, 1};
    int  m_es    [2];   // enabled scan edges since entering the current mode
    bit  m_mode  [2];
    int  m_data  [2];
    int  m_sel   [2];
    bit  m_valid [2];
    bit  m_wrap  [2];

    int tests = 0;
    int fails = 0;

    function automatic int chan_val(int k);
        return int'((data_a >> (8 * k)) & 32'hFF);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_es[i] = 0; m_mode[i] = 0; m_data[i] = 0;
            m_sel[i] = 0; m_valid[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rs_n || clr) begin
                m_es[i] = 0; m_mode[i] = 0; m_data[i] = 0;
                m_sel[i] = 0; m_valid[i] = 0; m_wrap[i] = 0;
            end else if (mode != m_mode[i]) begin
                m_mode[i] = mode; m_es[i] = 0;
                m_valid[i] = 0; m_wrap[i] = 0;
            end else if (!en) begin
                m_valid[i] = 0; m_wrap[i] = 0;
            end else if (!mode) begin
                m_sel[i]   = int'(con);
                m_data[i]  = (int'(con) < m_n[i]) ? chan_val(int'(con)) : 0;
                m_valid[i] = 1; m_wrap[i] = 0;
            end else begin
                m_es[i]++;
                if (m_es[i] % m_dwell[i] == 0) begin
                    int k;
                    k = (m_es[i] / m_dwell[i] - 1) % m_n[i];
                    m_data[i] = chan_val(k); m_sel[i] = k;
                    m_valid[i] = 1; m_wrap[i] = (k == m_n[i] - 1);
                end else begin
                    m_valid[i] = 0; m_wrap[i] = 0;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(string step_tag);
        check({step_tag, " a_data"},  32'(a_data),  32'(m_data[0]));
        check({step_tag, " a_sel"},   32'(a_sel),   32'(m_sel[0]));
        check({step_tag, " a_valid"}, 32'(a_valid), 32'(m_valid[0]));
        check({step_tag, " a_wrap"},  32'(a_wrap),  32'(m_wrap[0]));
        check({step_tag, " b_data"},  32'(b_data),  32'(m_data[1]));
        check({step_tag, " b_sel"},   32'(b_sel),   32'(m_sel[1]));
        check({step_tag, " b_valid"}, 32'(b_valid), 32'(m_valid[1]));
        check({step_tag, " b_wrap"},  32'(b_wrap),  32'(m_wrap[1]));
    endtask

    // ---------------- driver ----------------
    task automatic step(string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(bit m, bit e, bit c, logic [1:0] cn);
        mode = m; en = e; clr = c; con = cn;
    endtask

    task automatic async_reset(string tag);
        #2;
        rs_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rs_n = 1'b0; data_a = 32'h44332211;
        drive(0, 0, 0, 2'd0);
        #12;
        model_reset();
        check_all("reset");
        step("reset_hold");

        // Release in manual mode, select channel 2.
        rs_n = 1'b1;
        drive(0, 1, 0, 2'd2);
        step("manual_first");

        // Manual sweep: channel 3 on B (N=3) is out of range and reads 0.
        for (int k = 0; k < 4; k++) begin
            con = 2'(k);
            step("manual_sweep");
        end

        // Scan: mode-change edge plus one full pass of A (12 cycles).
        drive(1, 1, 0, 2'd1);
        for (int k = 0; k < 13; k++) step("scan_pass");

        // Enable gap mid-dwell.
        for (int k = 0; k < 4; k++) step("gap_pre");
        en = 1'b0;
        for (int k = 0; k < 5; k++) step("gap_off");
        en = 1'b1;
        for (int k = 0; k < 10; k++) step("gap_post");

        // Asynchronous reset mid-scan, then release in manual.
        async_reset("async_rst");
        step("async_rst_edge");
        rs_n = 1'b1;
        drive(0, 1, 0, 2'd2);
        step("post_rst_manual");

        // Clear together with a mode change.
        drive(1, 1, 1, 2'd0);
        step("clr_mode");
        clr = 1'b0;

        // Enter scan, reach cnt=DWELL-1 on A, then change back to manual.
        step("scan_entry");
        step("scan_c1");
        step("scan_c2");
        drive(0, 1, 0, 2'd1);
        step("mode_at_last");
        step("manual_after");

        // Randomised phase.
        for (int k = 0; k < 400; k++) begin
            data_a = $urandom;
            con    = 2'($urandom_range(0, 3));
            en     = ($urandom_range(0, 9) != 0);
            clr    = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 79) == 0) begin
                async_reset("rand_rst");
                step("rand_rst_edge");
                rs_n = 1'b1;
            end
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
